demuxn: RTL and testbench

- Clocked four-phase (return-to-zero) handshake demultiplexer with M output channels.
- The data channel (r_i/a_i/d_i) and the control channel (rctl_i/dctl_i/actl_i) are joined.
- The control channel carries a binary lane index; that index steers one data token to exactly one output channel.
- Generalises the two-way demux: parametrised lane count, a registered data path and an explicit handshake state machine.
- Sits in the condflow layer between token producers and conditional consumers.

---
 rtl/demuxn_if.sv | 28 ++
 rtl/demuxn.sv | 109 ++++++++++
 tb/tb_demuxn.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/demuxn_if.sv
// Handshake bundle for demuxn. It carries the joined data/control request side
// and the M-lane output side. demuxn connects to the slave modport.
interface demuxn_if #(
   parameter int N = 1,
   parameter int M = 4
);
   localparam int SW = $clog2(M);

   logic          r_i;
   logic          a_i;
   logic [N-1:0]  d_i;
   logic          rctl_i;
   logic [SW-1:0] dctl_i;
   logic          actl_i;
   logic [M-1:0]  r_o;
   logic [M-1:0]  a_o;
   logic [N-1:0]  d_o;

   modport master (
      output r_i, d_i, rctl_i, dctl_i, a_o,
      input  a_i, actl_i, r_o, d_o
   );

   modport slave (
      input  r_i, d_i, rctl_i, dctl_i, a_o,
      output a_i, actl_i, r_o, d_o
   );
endinterface

// File: rtl/demuxn.sv
// Four-phase handshake demultiplexer: a joined data+control token is steered to one of M lanes.
// Optional macro DEMUXN_SINK_EN: an out-of-range lane index is consumed silently instead of clamped.
module demuxn #(
   parameter int N = 1,
   parameter int M = 4
) (
   input logic     clk,
   input logic     rst,
   demuxn_if.slave bus
);
   localparam int SW = $clog2(M);

`ifdef DEMUXN_SINK_EN
   localparam bit SINK_EN = 1'b1;
`else
   localparam bit SINK_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, SEND, ACK} state_t;

   state_t        state, next_state;
   logic [SW-1:0] sel, next_sel, lane;
   logic [M-1:0]  r_o_q, next_r_o;
   logic [N-1:0]  d_q, next_d;
   logic          ack_q, next_ack;
   logic          sunk_q, next_sunk;
   logic          out_of_range;

   // Out-of-range indices only exist when M leaves part of the select space unused.
   generate
      if ((1 << SW) == M) begin : g_pow2
         assign out_of_range = 1'b0;
      end else begin : g_partial
         assign out_of_range = (bus.dctl_i > SW'(M - 1));
      end
   endgenerate

   assign lane = out_of_range ? SW'(M - 1) : bus.dctl_i;

   always_comb begin
      next_state = state;
      next_sel   = sel;
      next_r_o   = r_o_q;
      next_d     = d_q;
      next_ack   = ack_q;
      next_sunk  = sunk_q;
      unique case (state)
         IDLE: begin
            if (bus.r_i && bus.rctl_i) begin
               next_d   = bus.d_i;
               next_sel = lane;
               if (SINK_EN && out_of_range) begin
                  next_ack   = 1'b1;
                  next_sunk  = 1'b1;
                  next_state = ACK;
               end else begin
                  next_r_o   = M'(1) << lane;
                  next_sunk  = 1'b0;
                  next_state = SEND;
               end
            end
         end
         SEND: begin
            if (bus.a_o[sel]) begin
               next_r_o   = '0;
               next_ack   = 1'b1;
               next_state = ACK;
            end
         end
         ACK: begin
            // A sunk token has no lane partner, so only the producers must release.
            if (!bus.r_i && !bus.rctl_i && (!bus.a_o[sel] || sunk_q)) begin
               next_ack   = 1'b0;
               next_sunk  = 1'b0;
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
            next_r_o   = '0;
            next_ack   = 1'b0;
            next_sunk  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         sel    <= '0;
         r_o_q  <= '0;
         d_q    <= '0;
         ack_q  <= 1'b0;
         sunk_q <= 1'b0;
      end else begin
         state  <= next_state;
         sel    <= next_sel;
         r_o_q  <= next_r_o;
         d_q    <= next_d;
         ack_q  <= next_ack;
         sunk_q <= next_sunk;
      end
   end

   assign bus.r_o    = r_o_q;
   assign bus.d_o    = d_q;
   assign bus.a_i    = ack_q;
   assign bus.actl_i = ack_q;
endmodule

// File: tb/tb_demuxn.sv
// Bench for demuxn: a 4-lane and a 3-lane instance driven by randomized four-phase partners,
// with a queue-based scoreboard checking which lane each token reaches and its data.
module tb_demuxn;
   localparam int N  = 8;
   localparam int MA = 4;
   localparam int MB = 3;

`ifdef DEMUXN_SINK_EN
   localparam bit SINK = 1'b1;
`else
   localparam bit SINK = 1'b0;
`endif

   typedef struct {
      int           lane;
      logic [N-1:0] data;
   } token_t;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   token_t exp_a[$];
   token_t exp_b[$];

   always #5 clk = ~clk;

   demuxn_if #(.N(N), .M(MA)) bus_a ();
   demuxn_if #(.N(N), .M(MB)) bus_b ();

   demuxn #(.N(N), .M(MA)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
   demuxn #(.N(N), .M(MB)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] one_hot(input int lane);
      return (lane < 0) ? 32'd0 : (32'd1 << lane);
   endfunction

   // Random activity on every lane acknowledge except the one carrying the token.
   function automatic logic [MA-1:0] noise(input int lane);
      logic [MA-1:0] n;
      n = MA'($urandom);
      return n & ~(MA'(1) << lane);
   endfunction

   // Scoreboard monitors: a token is presented either by a lane request or, when sunk, by a bare acknowledge.
   initial begin : mon_a
      logic [MA-1:0] prev_r;
      logic          prev_ack;
      bit            shown;
      token_t        t;
      prev_r = '0; prev_ack = 1'b0; shown = 1'b0;
      forever begin
         @(negedge clk);
         if (rst !== 1'b1) begin
            prev_r = '0; prev_ack = 1'b0; shown = 1'b0;
         end else begin
            if (bus_a.r_o != '0 && prev_r == '0) begin
               if (exp_a.size() == 0) begin
                  checkOutput("a_unexpected_req", bus_a.r_o, 0);
               end else begin
                  t = exp_a.pop_front();
                  checkOutput("a_lane", bus_a.r_o, one_hot(t.lane));
                  checkOutput("a_data", bus_a.d_o, t.data);
               end
               shown = 1'b1;
            end
            if (bus_a.a_i && !prev_ack) begin
               if (!shown) begin
                  if (exp_a.size() == 0) begin
                     checkOutput("a_unexpected_ack", bus_a.a_i, 0);
                  end else begin
                     t = exp_a.pop_front();
                     checkOutput("a_sink_lane", bus_a.r_o, one_hot(t.lane));
                  end
               end
               shown = 1'b0;
            end
            prev_r   = bus_a.r_o;
            prev_ack = bus_a.a_i;
         end
      end
   end

   initial begin : mon_b
      logic [MB-1:0] prev_r;
      logic          prev_ack;
      bit            shown;
      token_t        t;
      prev_r = '0; prev_ack = 1'b0; shown = 1'b0;
      forever begin
         @(negedge clk);
         if (rst !== 1'b1) begin
            prev_r = '0; prev_ack = 1'b0; shown = 1'b0;
         end else begin
            if (bus_b.r_o != '0 && prev_r == '0) begin
               if (exp_b.size() == 0) begin
                  checkOutput("b_unexpected_req", bus_b.r_o, 0);
               end else begin
                  t = exp_b.pop_front();
                  checkOutput("b_lane", bus_b.r_o, one_hot(t.lane));
                  checkOutput("b_data", bus_b.d_o, t.data);
               end
               shown = 1'b1;
            end
            if (bus_b.a_i && !prev_ack) begin
               if (!shown) begin
                  if (exp_b.size() == 0) begin
                     checkOutput("b_unexpected_ack", bus_b.a_i, 0);
                  end else begin
                     t = exp_b.pop_front();
                     checkOutput("b_sink_lane", bus_b.r_o, one_hot(t.lane));
                     checkOutput("b_sink_data", bus_b.d_o, t.data);
                  end
               end
               shown = 1'b0;
            end
            prev_r   = bus_b.r_o;
            prev_ack = bus_b.a_i;
         end
      end
   end

   // One complete token on the 4-lane instance with randomized join skew, ack delay and release order.
   task automatic applyStimulus(input logic [N-1:0] d, input int idx, input int join_gap, input int ack_dly);
      token_t t;
      int     cyc;
      bit     ctl_first;
      bit     all_at_once;
      ctl_first   = 1'($urandom);
      all_at_once = 1'($urandom);
      @(negedge clk);
      bus_a.d_i    = d;
      bus_a.dctl_i = 2'(idx);
      bus_a.a_o    = noise(idx);
      if (ctl_first) bus_a.rctl_i = 1'b1;
      else           bus_a.r_i    = 1'b1;
      for (int i = 0; i < join_gap; i++) begin
         @(negedge clk);
         checkOutput("join_hold_r_o", bus_a.r_o, 0);
         checkOutput("join_hold_a_i", bus_a.a_i, 0);
         bus_a.a_o = noise(idx);
      end
      t.lane = idx;
      t.data = d;
      exp_a.push_back(t);
      bus_a.r_i    = 1'b1;
      bus_a.rctl_i = 1'b1;
      cyc = 0;
      do begin
         @(negedge clk);
         bus_a.a_o = noise(idx);
         cyc++;
      end while (!bus_a.r_o[idx] && cyc < 20);
      checkOutput("req_seen", bus_a.r_o, one_hot(idx));
      for (int i = 0; i < ack_dly; i++) begin
         @(negedge clk);
         checkOutput("ignored_lane_hold", bus_a.r_o, one_hot(idx));
         bus_a.a_o = noise(idx);
      end
      bus_a.a_o = noise(idx) | (MA'(1) << idx);
      @(negedge clk);
      checkOutput("ack_r_o_clear", bus_a.r_o, 0);
      checkOutput("ack_a_i", bus_a.a_i, 1);
      checkOutput("ack_actl_i", bus_a.actl_i, 1);
      if (all_at_once) begin
         bus_a.r_i = 1'b0; bus_a.rctl_i = 1'b0; bus_a.a_o = noise(idx);
      end else begin
         bus_a.r_i = 1'b0; bus_a.a_o = noise(idx) | (MA'(1) << idx);
         @(negedge clk);
         checkOutput("partial_release_1", bus_a.a_i, 1);
         bus_a.rctl_i = 1'b0; bus_a.a_o = noise(idx) | (MA'(1) << idx);
         @(negedge clk);
         checkOutput("partial_release_2", bus_a.actl_i, 1);
         bus_a.a_o = noise(idx);
      end
      @(negedge clk);
      checkOutput("release_a_i", bus_a.a_i, 0);
      checkOutput("release_actl_i", bus_a.actl_i, 0);
      checkOutput("d_o_hold", bus_a.d_o, d);
      bus_a.a_o = '0;
   endtask

   // One token on the 3-lane instance, where index 3 is out of range.
   task automatic applyStimulusB(input logic [N-1:0] d, input int idx);
      token_t t;
      int     lane;
      lane = (idx < MB) ? idx : (SINK ? -1 : MB - 1);
      @(negedge clk);
      bus_b.d_i    = d;
      bus_b.dctl_i = 2'(idx);
      bus_b.r_i    = 1'b1;
      bus_b.rctl_i = 1'b1;
      t.lane = lane;
      t.data = d;
      exp_b.push_back(t);
      @(negedge clk);
      if (lane < 0) begin
         checkOutput("b_sink_ack", {bus_b.a_i, bus_b.actl_i}, 2'b11);
         checkOutput("b_sink_r_o", bus_b.r_o, 0);
         bus_b.r_i = 1'b0; bus_b.rctl_i = 1'b0; bus_b.a_o = '1;
         @(negedge clk);
         checkOutput("b_sink_release", bus_b.a_i, 0);
      end else begin
         checkOutput("b_req", bus_b.r_o, one_hot(lane));
         bus_b.a_o[lane] = 1'b1;
         @(negedge clk);
         checkOutput("b_ack", {bus_b.a_i, bus_b.actl_i, 3'(bus_b.r_o)}, 5'b11000);
         bus_b.r_i = 1'b0; bus_b.rctl_i = 1'b0; bus_b.a_o = '0;
         @(negedge clk);
         checkOutput("b_release", bus_b.a_i, 0);
      end
      checkOutput("b_d_o_hold", bus_b.d_o, d);
      bus_b.a_o = '0;
   endtask

   task automatic clear_inputs();
      bus_a.r_i = 1'b0; bus_a.rctl_i = 1'b0; bus_a.d_i = '0; bus_a.dctl_i = '0; bus_a.a_o = '0;
      bus_b.r_i = 1'b0; bus_b.rctl_i = 1'b0; bus_b.d_i = '0; bus_b.dctl_i = '0; bus_b.a_o = '0;
   endtask

   initial begin : watchdog
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      int cyc;
      rst = 1'b1;
      clear_inputs();
      #1 rst = 1'b0;
      bus_a.r_i = 1'($urandom); bus_a.rctl_i = 1'($urandom); bus_a.d_i = N'($urandom);
      bus_a.dctl_i = 2'($urandom); bus_a.a_o = MA'($urandom);
      #1;
      checkOutput("rst_r_o", bus_a.r_o, 0);
      checkOutput("rst_ack", {bus_a.a_i, bus_a.actl_i}, 0);
      checkOutput("rst_d_o", bus_a.d_o, 0);
      repeat (2) @(negedge clk);
      checkOutput("rst_hold_r_o", bus_a.r_o, 0);
      clear_inputs();
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("idle_r_o", bus_a.r_o, 0);
      checkOutput("idle_a_i", bus_a.a_i, 0);

      $display("[TB] basic, join and ignored-lane transfers");
      applyStimulus(8'hA5, 2, 0, 0);
      applyStimulus(8'h17, 0, 5, 2);
      applyStimulus(8'hE2, 2, 1, 4);

      $display("[TB] 3-lane instance including out-of-range index");
      applyStimulusB(8'h3C, 3);
      applyStimulusB(8'h81, 1);
      for (int i = 0; i < 8; i++) applyStimulusB(N'($urandom), $urandom_range(0, 3));

      $display("[TB] reset during SEND");
      @(negedge clk);
      bus_a.d_i = 8'h5A; bus_a.dctl_i = 2'd1; bus_a.r_i = 1'b1; bus_a.rctl_i = 1'b1;
      begin
         token_t t;
         t.lane = 1; t.data = 8'h5A;
         exp_a.push_back(t);
      end
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!bus_a.r_o[1] && cyc < 20);
      checkOutput("midop_req", bus_a.r_o, 4'b0010);
      #2 rst = 1'b0;
      #1;
      checkOutput("async_rst_r_o", bus_a.r_o, 0);
      checkOutput("async_rst_d_o", bus_a.d_o, 0);
      exp_a.delete();
      exp_b.delete();
      clear_inputs();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      applyStimulus(8'hC3, 3, 0, 1);

      $display("[TB] randomized tokens");
      for (int i = 0; i < 40; i++)
         applyStimulus(N'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));

      repeat (3) @(negedge clk);
      checkOutput("a_queue_drained", exp_a.size(), 0);
      checkOutput("b_queue_drained", exp_b.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
